// File: rtl/prbs_check_ctrl.sv
// Self-synchronising PRBS7 (x^7+x^6+1) checker: seeds from the received stream,
// confirms lock over LOCK_LEN bits, then counts bits/errors over a fixed window.
module prbs_check_ctrl #(
  parameter int unsigned LOCK_LEN     = 32,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned TOTAL_BITS   = 100000,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned ERR_W        = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             locked,
  output logic             lock_fail,
  output logic [CNT_W-1:0] bit_count,
  output logic [ERR_W-1:0] err_count,
  output logic             sim_done
);

  typedef enum logic [1:0] {SEED, LOCK, COUNT, DONE} state_t;

  state_t             state_q, state_d;
  logic [6:0]         lfsr_q, lfsr_d;
  logic [2:0]         seed_cnt_q, seed_cnt_d;
  logic [CNT_W-1:0]   run_q, run_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               locked_q, locked_d;
  logic               lock_fail_q, lock_fail_d;
  logic               sim_done_q, sim_done_d;

  logic               exp_bit;
  logic [CNT_W-1:0]   run_inc, tmo_inc, bit_inc;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    seed_cnt_d  = seed_cnt_q;
    run_d       = run_q;
    tmo_d       = tmo_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    locked_d    = locked_q;
    lock_fail_d = lock_fail_q;
    sim_done_d  = sim_done_q;

    exp_bit = lfsr_q[6] ^ lfsr_q[5];
    run_inc = run_q + 1'b1;
    tmo_inc = tmo_q + 1'b1;
    bit_inc = bit_cnt_q + 1'b1;

    if (in_valid) begin
      case (state_q)
        SEED: begin
          lfsr_d = {lfsr_q[5:0], in_bit};
          tmo_d  = tmo_inc;
          if (seed_cnt_q == 3'd6) begin
            seed_cnt_d = '0;
            run_d      = '0;
            state_d    = LOCK;
          end else begin
            seed_cnt_d = seed_cnt_q + 3'd1;
          end
        end
        LOCK: begin
          lfsr_d = {lfsr_q[5:0], exp_bit};
          tmo_d  = tmo_inc;
          // An all-zero register predicts zeros forever, so it is never a valid lock.
          if ((in_bit == exp_bit) && (lfsr_q != '0)) begin
            run_d = run_inc;
            if (run_inc == CNT_W'(LOCK_LEN)) begin
              state_d  = COUNT;
              locked_d = 1'b1;
            end
          end else begin
            state_d    = SEED;
            seed_cnt_d = '0;
            run_d      = '0;
          end
        end
        COUNT: begin
          lfsr_d    = {lfsr_q[5:0], exp_bit};
          bit_cnt_d = bit_inc;
          if ((in_bit != exp_bit) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (bit_inc == CNT_W'(TOTAL_BITS)) begin
            state_d    = DONE;
            sim_done_d = 1'b1;
          end
        end
        default: ;
      endcase

      // Lock completion on the same beat wins over the timeout.
      if (((state_q == SEED) || (state_q == LOCK)) &&
          (tmo_inc == CNT_W'(LOCK_TIMEOUT)) && (state_d != COUNT)) begin
        state_d     = DONE;
        lock_fail_d = 1'b1;
        sim_done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEED;
      lfsr_q      <= '0;
      seed_cnt_q  <= '0;
      run_q       <= '0;
      tmo_q       <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      lock_fail_q <= 1'b0;
      sim_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      seed_cnt_q  <= seed_cnt_d;
      run_q       <= run_d;
      tmo_q       <= tmo_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      lock_fail_q <= lock_fail_d;
      sim_done_q  <= sim_done_d;
    end
  end

  assign locked    = locked_q;
  assign lock_fail = lock_fail_q;
  assign bit_count = bit_cnt_q;
  assign err_count = err_cnt_q;
  assign sim_done  = sim_done_q;

endmodule

// File: tb/tb_prbs_check_ctrl.sv
// Scoreboard bench for prbs_check_ctrl: directed PRBS7 streams, expected lock/done
// events queued by the stimulus and checked by an independent monitor.
module tb_prbs_check_ctrl;

  localparam int unsigned T_LOCK_LEN = 32;
  localparam int unsigned T_TMO      = 4096;
  localparam int unsigned T_TOTAL    = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        locked, lock_fail, sim_done;
  logic [31:0] bit_count;
  logic [23:0] err_count;

  prbs_check_ctrl #(
    .LOCK_LEN(T_LOCK_LEN),
    .LOCK_TIMEOUT(T_TMO),
    .TOTAL_BITS(T_TOTAL),
    .CNT_W(32),
    .ERR_W(24)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_bit(in_bit),
    .locked(locked),
    .lock_fail(lock_fail),
    .bit_count(bit_count),
    .err_count(err_count),
    .sim_done(sim_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tno;
    int kind;   // 0: locked rises, 1: sim_done rises
    int beat;
    int lk;
    int lf;
    int sd;
    int bc;
    int ec;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         beats;
  int         lock_beat_exp = -1;
  logic [6:0] tx = 7'h01;
  logic       prev_l = 1'b0;
  logic       prev_d = 1'b0;

  task automatic check(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Valid beats clocked into the DUT since the last reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) beats <= 0;
    else if (in_valid) beats <= beats + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_l = 1'b0;
      prev_d = 1'b0;
    end else begin
      if (lock_beat_exp >= 0 && locked) begin
        int e;
        e = beats - lock_beat_exp;
        if (e > int'(T_TOTAL)) e = int'(T_TOTAL);
        check("bit_count_model", bit_count, e);
      end
      if (prev_l) check("locked_hold", locked, 1);
      if ((locked && !prev_l) || (sim_done && !prev_d)) begin
        check("event_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          exp_t x;
          string tg;
          x  = sb_q.pop_front();
          tg = $sformatf("t%0d_%s", x.tno, (x.kind == 1) ? "done" : "lock");
          check({tg, "_beat"},      beats,     x.beat);
          check({tg, "_locked"},    locked,    x.lk);
          check({tg, "_lock_fail"}, lock_fail, x.lf);
          check({tg, "_sim_done"},  sim_done,  x.sd);
          check({tg, "_bit_count"}, bit_count, x.bc);
          check({tg, "_err_count"}, err_count, x.ec);
        end
      end
      prev_l = locked;
      prev_d = sim_done;
    end
  end

  task automatic push(input int tno, input int kind, input int beat, input int lk,
                      input int lf, input int sd, input int bc, input int ec);
    exp_t x;
    x.tno = tno; x.kind = kind; x.beat = beat;
    x.lk = lk; x.lf = lf; x.sd = sd; x.bc = bc; x.ec = ec;
    sb_q.push_back(x);
  endtask

  task automatic send(input bit vld, input bit flip);
    logic b;
    @(negedge clk);
    in_valid = vld;
    if (vld) begin
      b = tx[6] ^ tx[5];
      tx = {tx[5:0], b};
      in_bit = b ^ flip;
    end else begin
      in_bit = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_stream(input int n, input int f1, input int f2, input int f3);
    for (int b = 1; b <= n; b++) send(1'b1, (b == f1) || (b == f2) || (b == f3));
  endtask

  task automatic drain(input int tno);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check($sformatf("t%0d_queue_drained", tno), sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic check_zero(input string tg);
    check({tg, "_locked"},    locked,    0);
    check({tg, "_lock_fail"}, lock_fail, 0);
    check({tg, "_sim_done"},  sim_done,  0);
    check({tg, "_bit_count"}, bit_count, 0);
    check({tg, "_err_count"}, err_count, 0);
  endtask

  task automatic do_reset(input int tno);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    lock_beat_exp = -1;
    @(negedge clk);
    @(negedge clk);
    check_zero($sformatf("t%0d_reset", tno));
    rst_n = 1'b1;
    tx = 7'h01;
  endtask

  initial begin
    // T1: clean stream, continuous valid
    do_reset(1);
    lock_beat_exp = 39;
    push(1, 0, 39, 1, 0, 0, 0, 0);
    push(1, 1, 1039, 1, 0, 1, 1000, 0);
    run_stream(1039, 0, 0, 0);
    drain(1);

    // T2: window bits 100, 500, 501 inverted
    do_reset(2);
    lock_beat_exp = 39;
    push(2, 0, 39, 1, 0, 0, 0, 0);
    push(2, 1, 1039, 1, 0, 1, 1000, 3);
    run_stream(1039, 139, 539, 540);
    drain(2);

    // T3: flip at LOCK beat 10 (stream beat 17) forces reseed
    do_reset(3);
    lock_beat_exp = 56;
    push(3, 0, 56, 1, 0, 0, 0, 0);
    push(3, 1, 1056, 1, 0, 1, 1000, 0);
    run_stream(1056, 17, 0, 0);
    drain(3);

    // T4: constant zero input times out
    do_reset(4);
    push(4, 1, 4096, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit = 1'b0;
    end
    drain(4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_after_locked",    locked,    0);
    check("t4_after_lock_fail", lock_fail, 1);
    check("t4_after_sim_done",  sim_done,  1);
    check("t4_after_bit_count", bit_count, 0);

    // T5: in_valid pattern 1,0,0,1
    do_reset(5);
    lock_beat_exp = 39;
    push(5, 0, 39, 1, 0, 0, 0, 0);
    push(5, 1, 1039, 1, 0, 1, 1000, 0);
    begin
      int v;
      v = 0;
      for (int i = 0; v < 1039; i++) begin
        bit vld;
        vld = ((i % 4) == 0) || ((i % 4) == 3);
        send(vld, 1'b0);
        if (vld) v++;
      end
    end
    drain(5);

    // T6: async reset mid-count at bit_count=400, then full relock and window
    do_reset(6);
    lock_beat_exp = 39;
    push(6, 0, 39, 1, 0, 0, 0, 0);
    run_stream(439, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("t6_pre_bit_count", bit_count, 400);
    #2 rst_n = 1'b0;
    #1 check_zero("t6_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(6, 0, 39, 1, 0, 0, 0, 0);
    push(6, 1, 1039, 1, 0, 1, 1000, 0);
    run_stream(1039, 0, 0, 0);
    drain(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
